// File: rtl/mod_99_4_7_respond.sv
// MAC Merge respond-side handshake: answers verify mPackets with
// respond requests, enforces a post-respond gap, buffers one verify.
module mod_99_4_7_respond #(
  parameter int IPG_CYCLES = 12,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p_enable,
  input  logic             rx_verify_det,
  input  logic             tx_respond_ack,
  output logic             send_r,
  output logic             ipg_active,
  output logic             rcv_v_pending,
  output logic [CNT_W-1:0] respond_count,
  output logic [CNT_W-1:0] verify_drop_count
);

  localparam int  GW      = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam int  LOADI   = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
  localparam bit  HAS_GAP = (IPG_CYCLES > 0);
  localparam logic [GW-1:0] GAP_LOAD = GW'(LOADI);

  typedef enum logic [1:0] {
    DISABLED,
    WAIT_VERIFY,
    SEND_RESPOND,
    IPG
  } state_e;

  state_e           state_q, state_d;
  logic             send_r_q, send_r_d;
  logic             ipg_act_q, ipg_act_d;
  logic             pend_q, pend_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] resp_q, resp_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ack_ok;
  logic             buf_v;

  // An ack only counts while a request is actually being presented.
  assign ack_ok = (state_q == SEND_RESPOND) && send_r_q && tx_respond_ack;

  // Next state, verify buffering, counters and registered output decode.
  // With no gap, an ack that chains into another respond keeps the
  // state in SEND_RESPOND but drops send_r for one cycle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    gap_d   = gap_q;
    resp_d  = resp_q;
    drop_d  = drop_q;
    buf_v   = 1'b0;
    if (!p_enable) begin
      state_d = DISABLED;
      pend_d  = 1'b0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        DISABLED: begin
          state_d = WAIT_VERIFY;
        end
        WAIT_VERIFY: begin
          if (rx_verify_det) state_d = SEND_RESPOND;
        end
        SEND_RESPOND: begin
          if (ack_ok) begin
            if (resp_q != '1) resp_d = resp_q + CNT_W'(1);
            if (HAS_GAP) begin
              state_d = IPG;
              gap_d   = GAP_LOAD;
              buf_v   = rx_verify_det;
            end else if (pend_q) begin
              pend_d  = 1'b0;
              buf_v   = rx_verify_det;
            end else if (!rx_verify_det) begin
              state_d = WAIT_VERIFY;
            end
          end else begin
            buf_v = rx_verify_det;
          end
        end
        IPG: begin
          if (gap_q == '0) begin
            if (pend_q) begin
              state_d = SEND_RESPOND;
              pend_d  = 1'b0;
              buf_v   = rx_verify_det;
            end else if (rx_verify_det) begin
              state_d = SEND_RESPOND;
            end else begin
              state_d = WAIT_VERIFY;
            end
          end else begin
            gap_d = gap_q - GW'(1);
            buf_v = rx_verify_det;
          end
        end
      endcase
      if (buf_v) begin
        if (pend_d) begin
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end else begin
          pend_d = 1'b1;
        end
      end
    end
    send_r_d  = (state_d == SEND_RESPOND) && !ack_ok;
    ipg_act_d = (state_d == IPG);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DISABLED;
      send_r_q  <= 1'b0;
      ipg_act_q <= 1'b0;
      pend_q    <= 1'b0;
      gap_q     <= '0;
      resp_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      send_r_q  <= send_r_d;
      ipg_act_q <= ipg_act_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
      resp_q    <= resp_d;
      drop_q    <= drop_d;
    end
  end

  assign send_r            = send_r_q;
  assign ipg_active        = ipg_act_q;
  assign rcv_v_pending     = pend_q;
  assign respond_count     = resp_q;
  assign verify_drop_count = drop_q;

endmodule

// File: tb/tb_mod_99_4_7_respond.sv
// Bench for mod_99_4_7_respond: vector table, hand sequences and
// randomized traffic against an abstract model (gap 12 and gap 0).
module tb_mod_99_4_7_respond;

  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  localparam int M_OFF  = 0;
  localparam int M_IDLE = 1;
  localparam int M_BUSY = 2;
  localparam int M_GAP  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    pen = '0;
  logic [1:0]    v = '0;
  logic [1:0]    ack = '0;
  logic [1:0]    s, g, p;
  logic [CW-1:0] rc0, dc0, rc1, dc1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_99_4_7_respond #(.IPG_CYCLES(12), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .p_enable(pen[0]),
    .rx_verify_det(v[0]), .tx_respond_ack(ack[0]),
    .send_r(s[0]), .ipg_active(g[0]), .rcv_v_pending(p[0]),
    .respond_count(rc0), .verify_drop_count(dc0)
  );

  mod_99_4_7_respond #(.IPG_CYCLES(0), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .p_enable(pen[1]),
    .rx_verify_det(v[1]), .tx_respond_ack(ack[1]),
    .send_r(s[1]), .ipg_active(g[1]), .rcv_v_pending(p[1]),
    .respond_count(rc1), .verify_drop_count(dc1)
  );

  typedef struct {
    bit u;
    bit en;
    bit vv;
    bit aa;
    int reps;
    bit es;
    bit eg;
    bit ep;
    int erc;
    int edc;
  } vec_t;

  typedef struct {
    int mode;
    bit req;
    int gap;
    bit pend;
    int rc;
    int dc;
  } mdl_t;

  vec_t tbl[$];
  mdl_t m[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int u, bit es, bit eg, bit ep,
                     int erc, int edc);
    logic [CW-1:0] arc, adc;
    arc = (u != 0) ? rc1 : rc0;
    adc = (u != 0) ? dc1 : dc0;
    n_chk++;
    if (s[u] !== es || g[u] !== eg || p[u] !== ep ||
        arc !== CW'(erc) || adc !== CW'(edc)) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got s=%b g=%b p=%b rc=%0d dc=%0d, want s=%b g=%b p=%b rc=%0d dc=%0d",
               nm, u, $time, s[u], g[u], p[u], arc, adc,
               es, eg, ep, erc, edc);
    end
  endtask

  task automatic row(bit u, bit en, bit vv, bit aa, int reps,
                     bit es, bit eg, bit ep, int erc, int edc);
    vec_t r;
    r.u = u; r.en = en; r.vv = vv; r.aa = aa; r.reps = reps;
    r.es = es; r.eg = eg; r.ep = ep; r.erc = erc; r.edc = edc;
    tbl.push_back(r);
  endtask

  // Abstract model: a request is busy until acked, then a gap of ipg
  // cycles; one verify may wait in a single slot, extras are dropped.
  function automatic mdl_t step(mdl_t cur, bit r, bit en, bit vv,
                                bit aa, int ipg);
    mdl_t n;
    bit take;
    n = cur;
    if (!r) begin
      n = '{M_OFF, 1'b0, 0, 1'b0, 0, 0};
      return n;
    end
    if (!en) begin
      n.mode = M_OFF; n.req = 1'b0; n.pend = 1'b0; n.gap = 0;
      return n;
    end
    take = vv;
    case (cur.mode)
      M_OFF: begin
        n.mode = M_IDLE; take = 1'b0;
      end
      M_IDLE: begin
        take = 1'b0;
        if (vv) begin n.mode = M_BUSY; n.req = 1'b1; end
      end
      M_BUSY: begin
        if (cur.req && aa) begin
          n.rc = (cur.rc < SAT) ? cur.rc + 1 : SAT;
          n.req = 1'b0;
          if (ipg > 0) begin
            n.mode = M_GAP; n.gap = ipg;
          end else if (cur.pend) begin
            n.pend = 1'b0;
          end else if (vv) begin
            take = 1'b0;
          end else begin
            n.mode = M_IDLE;
          end
        end else if (!cur.req) begin
          n.req = 1'b1;
        end
      end
      M_GAP: begin
        if (cur.gap == 1) begin
          if (cur.pend) begin
            n.pend = 1'b0; n.mode = M_BUSY; n.req = 1'b1;
          end else if (vv) begin
            take = 1'b0; n.mode = M_BUSY; n.req = 1'b1;
          end else begin
            n.mode = M_IDLE;
          end
        end else begin
          n.gap = cur.gap - 1;
        end
      end
      default: ;
    endcase
    if (take) begin
      if (n.pend) n.dc = (n.dc < SAT) ? n.dc + 1 : SAT;
      else n.pend = 1'b1;
    end
    return n;
  endfunction

  initial begin
    // Reset with p_enable high: everything zero.
    rst_n = 1'b0; pen = 2'b11;
    tick(); tick();
    chk("reset", 0, 0, 0, 0, 0, 0);
    chk("reset", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic handshake with 12-cycle gap.
    row(0, 1, 0, 0, 4,  0, 0, 0, 0, 0);
    row(0, 1, 1, 0, 1,  1, 0, 0, 0, 0);
    row(0, 1, 0, 0, 3,  1, 0, 0, 0, 0);
    row(0, 1, 0, 1, 1,  0, 1, 0, 1, 0);
    row(0, 1, 0, 0, 11, 0, 1, 0, 1, 0);
    row(0, 1, 0, 0, 2,  0, 0, 0, 1, 0);
    // Verify during gap is buffered and served at gap end.
    row(0, 1, 1, 0, 1,  1, 0, 0, 1, 0);
    row(0, 1, 0, 1, 1,  0, 1, 0, 2, 0);
    row(0, 1, 0, 0, 1,  0, 1, 0, 2, 0);
    row(0, 1, 1, 0, 1,  0, 1, 1, 2, 0);
    row(0, 1, 0, 0, 9,  0, 1, 1, 2, 0);
    row(0, 1, 0, 0, 1,  1, 0, 0, 2, 0);
    row(0, 1, 0, 1, 1,  0, 1, 0, 3, 0);
    row(0, 1, 0, 0, 11, 0, 1, 0, 3, 0);
    row(0, 1, 0, 0, 1,  0, 0, 0, 3, 0);
    // Three verifies during one respond: one buffered, two dropped.
    row(0, 1, 1, 0, 1,  1, 0, 0, 3, 0);
    row(0, 1, 1, 0, 1,  1, 0, 1, 3, 0);
    row(0, 1, 1, 0, 1,  1, 0, 1, 3, 1);
    row(0, 1, 1, 0, 1,  1, 0, 1, 3, 2);
    row(0, 1, 0, 1, 1,  0, 1, 1, 4, 2);
    row(0, 1, 0, 0, 11, 0, 1, 1, 4, 2);
    row(0, 1, 0, 0, 1,  1, 0, 0, 4, 2);
    row(0, 1, 0, 1, 1,  0, 1, 0, 5, 2);
    row(0, 1, 0, 0, 11, 0, 1, 0, 5, 2);
    row(0, 1, 0, 0, 1,  0, 0, 0, 5, 2);
    // Disable mid-handshake; late ack and verify ignored; re-enable.
    row(0, 1, 1, 0, 1,  1, 0, 0, 5, 2);
    row(0, 1, 1, 0, 1,  1, 0, 1, 5, 2);
    row(0, 0, 0, 0, 1,  0, 0, 0, 5, 2);
    row(0, 0, 1, 1, 1,  0, 0, 0, 5, 2);
    row(0, 1, 0, 0, 1,  0, 0, 0, 5, 2);
    row(0, 1, 1, 0, 1,  1, 0, 0, 5, 2);
    row(0, 1, 0, 1, 1,  0, 1, 0, 6, 2);
    row(0, 1, 0, 0, 11, 0, 1, 0, 6, 2);
    row(0, 1, 0, 0, 1,  0, 0, 0, 6, 2);
    row(0, 1, 0, 1, 2,  0, 0, 0, 6, 2);
    // No-gap instance: ack+verify gives one low cycle then re-request.
    row(1, 1, 0, 0, 1,  0, 0, 0, 0, 0);
    row(1, 1, 1, 0, 1,  1, 0, 0, 0, 0);
    row(1, 1, 1, 1, 1,  0, 0, 0, 1, 0);
    row(1, 1, 0, 0, 1,  1, 0, 0, 1, 0);
    row(1, 1, 0, 1, 1,  0, 0, 0, 2, 0);
    row(1, 1, 0, 0, 2,  0, 0, 0, 2, 0);
    row(1, 1, 1, 0, 1,  1, 0, 0, 2, 0);
    row(1, 1, 1, 0, 1,  1, 0, 1, 2, 0);
    row(1, 1, 1, 1, 1,  0, 0, 1, 3, 0);
    row(1, 1, 0, 0, 1,  1, 0, 1, 3, 0);
    row(1, 1, 0, 1, 1,  0, 0, 0, 4, 0);
    row(1, 1, 0, 0, 1,  1, 0, 0, 4, 0);
    row(1, 1, 0, 1, 1,  0, 0, 0, 5, 0);
    row(1, 1, 0, 0, 1,  0, 0, 0, 5, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        pen = '0; v = '0; ack = '0;
        pen[tbl[i].u] = tbl[i].en;
        v[tbl[i].u]   = tbl[i].vv;
        ack[tbl[i].u] = tbl[i].aa;
        tick();
        chk($sformatf("vec%0d", i), int'(tbl[i].u), tbl[i].es,
            tbl[i].eg, tbl[i].ep, tbl[i].erc, tbl[i].edc);
      end
    end

    // Saturation of respond_count on the no-gap instance.
    rst_n = 1'b0; pen = '0; v = '0; ack = '0;
    tick();
    rst_n = 1'b1; pen[1] = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      v[1] = 1'b1; tick();
      v[1] = 1'b0; ack[1] = 1'b1; tick();
      ack[1] = 1'b0;
      if (k == 254) chk("sat255", 1, 0, 0, 0, 255, 0);
    end
    chk("sat_hold", 1, 0, 0, 0, 255, 0);
    v[1] = 1'b1; tick();
    v[1] = 1'b0;
    chk("sat_send", 1, 1, 0, 0, 255, 0);
    rst_n = 1'b0; ack[1] = 1'b1; tick();
    ack[1] = 1'b0;
    chk("mid_rst", 1, 0, 0, 0, 0, 0);

    // Randomized traffic on both instances against the model.
    rst_n = 1'b0; pen = 2'b11; v = '0; ack = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      m[i] = step(m[i], 1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("rand_rst", i, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        pen[i] = ($urandom_range(0, 39) != 0);
        v[i]   = ($urandom_range(0, 3) == 0);
        ack[i] = ($urandom_range(0, 2) == 0);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        m[i] = step(m[i], rst_n, pen[i], v[i], ack[i],
                    (i == 0) ? 12 : 0);
        chk("rand", i, (m[i].mode == M_BUSY) && m[i].req,
            m[i].mode == M_GAP, m[i].pend, m[i].rc, m[i].dc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
